// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered WIDTH-bit logic unit with 8-way op select and packet accumulate mode
// One output register with valid/ready; an IDLE/ACCUM FSM folds multi-beat packets into one result.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_acc,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y,
    output logic [CNT_W-1:0] o_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [WIDTH-1:0] operand_x;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = x & b;
            3'd1:    r = x | b;
            3'd2:    r = x ^ b;
            3'd3:    r = ~(x & b);
            3'd4:    r = ~(x | b);
            3'd5:    r = ~(x ^ b);
            3'd6:    r = x & ~b;
            default: r = x;
        endcase
        return r;
    endfunction

    // A held result blocks intake, which also freezes the accumulator and FSM.
    assign o_ready   = ~valid_q | i_ready;
    assign accept    = i_valid & o_ready;
    assign operand_x = (state_q == ACCUM) ? acc_q : i_a;
    assign result    = logic_op(i_op, operand_x, i_b);
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ocnt_q  <= ocnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && i_acc && !i_last) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept && i_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ocnt_d  = ocnt_q;
        valid_d = valid_q & ~i_ready;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (i_acc && !i_last) begin
                        acc_d = result;
                        cnt_d = CNT_W'(1);
                    end else begin
                        y_d     = result;
                        ocnt_d  = CNT_W'(1);
                        valid_d = 1'b1;
                    end
                end
                ACCUM: begin
                    if (i_last) begin
                        y_d     = result;
                        ocnt_d  = cnt_inc;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = result;
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_y     = y_q;
    assign o_cnt   = ocnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic [2:0] i_op;
    logic       i_acc;
    logic       i_last;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_y;
    logic [7:0] o_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] sweep_exp [8];

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_op    (i_op),
        .i_acc   (i_acc),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_y     (o_y),
        .o_cnt   (o_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc, input logic last);
        i_valid = v;
        i_a     = a;
        i_b     = b;
        i_op    = op;
        i_acc   = acc;
        i_last  = last;
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst   = 1'b1;
        i_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        total++;
        if (o_valid !== 1'b0 || o_y !== 8'h00 || o_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b y=%h cnt=%h want 0 00 00", o_valid, o_y, o_cnt);
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
        tick();
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_op_sweep;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 8'hF0, 8'hCC, 3'(k), 1'b0, 1'b0);
            #1;
            total++;
            if (o_ready !== 1'b1) begin
                bad++;
                $display("FAIL sweep_ready op=%0d: got %b want 1", k, o_ready);
            end
            tick();
            total++;
            if (o_valid !== 1'b1 || o_y !== sweep_exp[k] || o_cnt !== 8'd1) begin
                bad++;
                $display("FAIL sweep_result op=%0d: got valid=%b y=%h cnt=%h want 1 %h 01",
                         k, o_valid, o_y, o_cnt, sweep_exp[k]);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL sweep_drain: got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_accum_xor;
        drive(1'b1, 8'h12, 8'h34, 3'd2, 1'b1, 1'b0);
        tick();
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL accx_beat1_valid: got %b want 0", o_valid);
        end
        drive(1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hAA, 8'h56, 3'd2, 1'b0, 1'b0);
        tick();
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL accx_beat2_valid: got %b want 0", o_valid);
        end
        drive(1'b1, 8'h00, 8'h78, 3'd2, 1'b0, 1'b1);
        tick();
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'h08 || o_cnt !== 8'd3) begin
            bad++;
            $display("FAIL accx_result: got valid=%b y=%h cnt=%h want 1 08 03", o_valid, o_y, o_cnt);
        end
        drive(1'b1, 8'h3C, 8'h0F, 3'd0, 1'b1, 1'b1);
        tick();
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'h0C || o_cnt !== 8'd1) begin
            bad++;
            $display("FAIL accx_back_idle: got valid=%b y=%h cnt=%h want 1 0c 01", o_valid, o_y, o_cnt);
        end
    endtask

    task automatic test_mixed_ops;
        drive(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h00, 8'hF0, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h00, 8'hAA, 3'd2, 1'b0, 1'b1);
        tick();
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'h55 || o_cnt !== 8'd3) begin
            bad++;
            $display("FAIL mixed_result: got valid=%b y=%h cnt=%h want 1 55 03", o_valid, o_y, o_cnt);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_backpressure;
        drive(1'b1, 8'hA5, 8'h00, 3'd7, 1'b0, 1'b0);
        tick();
        i_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_y !== 8'hA5 || o_cnt !== 8'd1) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d: got ready=%b valid=%b y=%h cnt=%h want 0 1 a5 01",
                         c, o_ready, o_valid, o_y, o_cnt);
            end
            tick();
        end
        i_ready = 1'b1;
        #1;
        total++;
        if (o_ready !== 1'b1 || o_y !== 8'hA5) begin
            bad++;
            $display("FAIL bp_release: got ready=%b y=%h want 1 a5", o_ready, o_y);
        end
        tick();
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'h01 || o_cnt !== 8'd1) begin
            bad++;
            $display("FAIL bp_next: got valid=%b y=%h cnt=%h want 1 01 01", o_valid, o_y, o_cnt);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_packet;
        drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h00, 8'h04, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_y !== 8'h00 || o_cnt !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_outputs: got valid=%b y=%h cnt=%h want 0 00 00", o_valid, o_y, o_cnt);
        end
        #2;
        i_rst = 1'b0;
        tick();
        drive(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0);
        tick();
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'hFF || o_cnt !== 8'd1) begin
            bad++;
            $display("FAIL rst_mid_single: got valid=%b y=%h cnt=%h want 1 ff 01", o_valid, o_y, o_cnt);
        end
        drive(1'b1, 8'h10, 8'h01, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h00, 8'h02, 3'd1, 1'b0, 1'b1);
        tick();
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'h13 || o_cnt !== 8'd2) begin
            bad++;
            $display("FAIL rst_mid_fresh_pkt: got valid=%b y=%h cnt=%h want 1 13 02", o_valid, o_y, o_cnt);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'h00, (i == 299) ? 8'h80 : 8'h01, 3'd1, i == 0, i == 299);
            tick();
            if (i == 150) begin
                total++;
                if (o_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL sat_mid_valid: got %b want 0", o_valid);
                end
            end
        end
        total++;
        if (o_valid !== 1'b1 || o_y !== 8'h81 || o_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL sat_result: got valid=%b y=%h cnt=%h want 1 81 ff", o_valid, o_y, o_cnt);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        sweep_exp[0] = 8'hC0;
        sweep_exp[1] = 8'hFC;
        sweep_exp[2] = 8'h3C;
        sweep_exp[3] = 8'h3F;
        sweep_exp[4] = 8'h03;
        sweep_exp[5] = 8'hC3;
        sweep_exp[6] = 8'h30;
        sweep_exp[7] = 8'hF0;
        test_reset();
        test_op_sweep();
        test_accum_xor();
        test_mixed_ops();
        test_backpressure();
        test_reset_mid_packet();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
